// File: rtl/apu_pkg.sv
// Shared APU constants: length-counter lookup table and DAC helpers,
// used by the triangle, pulse and noise voices.
package apu_pkg;

    // Length counter load values, indexed by $400B/$4003/$400F bits [7:3].
    localparam logic [7:0] LENGTH_TABLE [0:31] = '{
        8'h0A, 8'hFE, 8'h14, 8'h02, 8'h28, 8'h04, 8'h50, 8'h06,
        8'hA0, 8'h08, 8'h3C, 8'h0A, 8'h0E, 8'h0C, 8'h1A, 8'h0E,
        8'h0C, 8'h10, 8'h18, 8'h12, 8'h30, 8'h14, 8'h60, 8'h16,
        8'hC0, 8'h18, 8'h48, 8'h1A, 8'h10, 8'h1C, 8'h20, 8'h1E
    };

    // DAC midpoint for the default 4-bit DAC.
    localparam logic [3:0] DAC_MID = 4'h7;

    // Midpoint code {0,1...1} for an arbitrary DAC width.
    function automatic int unsigned dac_mid(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/apu_length_counter.sv
// Length counter shared by the APU voices: load from the length table,
// decrement on the half-frame clock unless halted, forced to zero while
// the channel is disabled. Decrement saturates at zero.
module apu_length_counter #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             halt,
    input  logic             enable,
    input  logic             clock_en,
    output logic [LEN_W-1:0] count,
    output logic             active
);

    logic [LEN_W-1:0] cnt_d, cnt_q;

    // Next count: disable beats load, load beats the half-frame decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (clock_en && !halt && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count  = cnt_q;
    assign active = (cnt_q != '0);

endmodule

// File: rtl/triangle_channel.sv
// APU triangle voice: period timer, linear counter, length counter and a
// 2^SEQ_W-step sequencer driving a registered DAC code (triangle or saw).
// Optional macro TRI_ULTRASONIC_MUTE_EN: periods below 2 freeze the
// sequencer and park the output at the DAC midpoint.
module triangle_channel
    import apu_pkg::*;
#(
    parameter int TIMER_W = 11,
    parameter int SEQ_W   = 5,
    parameter int LIN_W   = 7,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_240hz,
    input  logic               enable_120hz,
    input  logic [7:0]         reg_4008,
    input  logic [7:0]         reg_400A,
    input  logic [7:0]         reg_400B,
    input  logic               reg_change,
    input  logic               channel_en,
    input  logic               saw_mode,
    output logic [SEQ_W-2:0]   tri_out,
    output logic               length_active
);

    localparam int DAC_W = SEQ_W - 1;

    logic               chg_s1_d, chg_s1_q;
    logic               chg_s2_d, chg_s2_q;
    logic               chg_s3_d, chg_s3_q;
    logic               reload;
    logic [TIMER_W-1:0] period;
    logic [TIMER_W-1:0] timer_d, timer_q;
    logic               tick_d, tick_q;
    logic [LIN_W-1:0]   lin_d, lin_q;
    logic               lin_flag_d, lin_flag_q;
    logic [SEQ_W-1:0]   seq_d, seq_q;
    logic [DAC_W-1:0]   tri_d, tri_q;
    logic [LEN_W-1:0]   len_cnt;
    logic               len_active;
    logic               ctrl;
    logic               mute;

    assign period = {reg_400B[TIMER_W-9:0], reg_400A};
    assign ctrl   = reg_4008[7];

`ifdef TRI_ULTRASONIC_MUTE_EN
    assign mute = (period < TIMER_W'(2));
`else
    assign mute = 1'b0;
`endif

    // reg_change crosses from the CPU domain; any edge after sync is a reload.
    always_comb begin
        chg_s1_d = reg_change;
        chg_s2_d = chg_s1_q;
        chg_s3_d = chg_s2_q;
    end

    assign reload = chg_s2_q ^ chg_s3_q;

    // Period timer: down-count, reload at terminal count, tick lands one clk later.
    always_comb begin
        if (timer_q == '0) begin
            timer_d = period;
            tick_d  = 1'b1;
        end else begin
            timer_d = timer_q - 1'b1;
            tick_d  = 1'b0;
        end
    end

    // Linear counter: a pending reload (or one arriving this clk) wins over the decrement.
    always_comb begin
        lin_d      = lin_q;
        lin_flag_d = lin_flag_q | reload;
        if (enable_240hz) begin
            if (lin_flag_q || reload) begin
                lin_d = reg_4008[LIN_W-1:0];
            end else if (lin_q != '0) begin
                lin_d = lin_q - 1'b1;
            end
            if (!ctrl) begin
                lin_flag_d = 1'b0;
            end
        end
    end

    // Sequencer steps only while both gating counters are non-zero.
    always_comb begin
        seq_d = seq_q;
        if (tick_q && (lin_q != '0) && (len_cnt != '0) && !mute) begin
            seq_d = seq_q + 1'b1;
        end
    end

    // Output code from the current step; silence just holds the step.
    always_comb begin
        if (mute) begin
            tri_d = DAC_W'(dac_mid(DAC_W));
        end else if (saw_mode) begin
            tri_d = ~seq_q[SEQ_W-1:1];
        end else if (seq_q[SEQ_W-1]) begin
            tri_d = seq_q[DAC_W-1:0];
        end else begin
            tri_d = ~seq_q[DAC_W-1:0];
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_s1_q   <= 1'b0;
            chg_s2_q   <= 1'b0;
            chg_s3_q   <= 1'b0;
            timer_q    <= '0;
            tick_q     <= 1'b0;
            lin_q      <= '0;
            lin_flag_q <= 1'b0;
            seq_q      <= '0;
            tri_q      <= '0;
        end else begin
            chg_s1_q   <= chg_s1_d;
            chg_s2_q   <= chg_s2_d;
            chg_s3_q   <= chg_s3_d;
            timer_q    <= timer_d;
            tick_q     <= tick_d;
            lin_q      <= lin_d;
            lin_flag_q <= lin_flag_d;
            seq_q      <= seq_d;
            tri_q      <= tri_d;
        end
    end

    apu_length_counter #(
        .LEN_W (LEN_W)
    ) u_length (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (reload),
        .load_val (LEN_W'(LENGTH_TABLE[reg_400B[7:3]])),
        .halt     (ctrl),
        .enable   (channel_en),
        .clock_en (enable_120hz),
        .count    (len_cnt),
        .active   (len_active)
    );

    assign tri_out       = tri_q;
    assign length_active = len_active;

endmodule

// File: tb/tb_triangle_channel.sv
// Directed bench for triangle_channel with an arithmetic reference model.
module tb_triangle_channel;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable_240hz, enable_120hz;
    logic [7:0] reg_4008, reg_400A, reg_400B;
    logic       reg_change, channel_en, saw_mode;
    logic [3:0] tri_out;
    logic       length_active;

    int vectors = 0;
    int miscompares = 0;

    triangle_channel dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_240hz  (enable_240hz),
        .enable_120hz  (enable_120hz),
        .reg_4008      (reg_4008),
        .reg_400A      (reg_400A),
        .reg_400B      (reg_400B),
        .reg_change    (reg_change),
        .channel_en    (channel_en),
        .saw_mode      (saw_mode),
        .tri_out       (tri_out),
        .length_active (length_active)
    );

    initial forever #5 clk = ~clk;

    localparam int LEN_TAB [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                                    12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

    typedef struct packed {
        int timer;
        int tick;
        int lin;
        int flag;
        int len;
        int seq;
        int out;
    } model_t;

    model_t m;
    int     m_cyc = 0;
    int     m_reload_edge = -1;

    function automatic model_t step(input model_t s, input bit rl, input bit c_en, input bit e240,
                                    input bit e120, input bit saw, input logic [7:0] r8,
                                    input logic [7:0] ra, input logic [7:0] rb);
        model_t n;
        int     per;
        int     preset;
        bit     ctl;
        bit     mute;
        bit     flag_eff;
        n        = s;
        per      = int'(rb[2:0]) * 256 + int'(ra);
        preset   = int'(r8[6:0]);
        ctl      = r8[7];
        mute     = 1'b0;
`ifdef TRI_ULTRASONIC_MUTE_EN
        mute     = (per < 2);
`endif
        flag_eff = (s.flag != 0) || rl;
        if (s.timer == 0) begin
            n.timer = per;
            n.tick  = 1;
        end else begin
            n.timer = s.timer - 1;
            n.tick  = 0;
        end
        n.flag = flag_eff ? 1 : 0;
        if (e240) begin
            n.lin = flag_eff ? preset : ((s.lin > 0) ? s.lin - 1 : 0);
            if (!ctl) n.flag = 0;
        end
        if (!c_en) n.len = 0;
        else if (rl) n.len = LEN_TAB[int'(rb[7:3])];
        else if (e120 && !ctl && s.len > 0) n.len = s.len - 1;
        if (s.tick != 0 && s.lin > 0 && s.len > 0 && !mute) n.seq = (s.seq + 1) % 32;
        if (mute) n.out = 7;
        else if (saw) n.out = 15 - s.seq / 2;
        else n.out = (s.seq < 16) ? 15 - s.seq : s.seq - 16;
        return n;
    endfunction

    always @(posedge clk) m_cyc <= m_cyc + 1;

    // Reference model state, advanced on every clock from the same inputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else m <= step(m, (m_cyc + 1) == m_reload_edge, channel_en, enable_240hz, enable_120hz,
                       saw_mode, reg_4008, reg_400A, reg_400B);
    end

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        vectors++;
        if (int'(tri_out) != m.out) begin
            miscompares++;
            $display("FAIL cyc_tri_out t=%0t got %0d expected %0d", $time, tri_out, m.out);
        end
        vectors++;
        if (length_active != (m.len != 0)) begin
            miscompares++;
            $display("FAIL cyc_length_active t=%0t got %0d expected %0d", $time, length_active, (m.len != 0));
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input bit half);
        enable_240hz = 1'b1;
        enable_120hz = half;
        @(negedge clk);
        enable_240hz = 1'b0;
        enable_120hz = 1'b0;
    endtask

    task automatic toggle();
        reg_change    = ~reg_change;
        m_reload_edge = m_cyc + 3;
    endtask

    int chg_v[$];
    int chg_t[$];

    task automatic record(input int n);
        int prev;
        chg_v.delete();
        chg_t.delete();
        prev = int'(tri_out);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (int'(tri_out) != prev) begin
                chg_v.push_back(int'(tri_out));
                chg_t.push_back(i);
            end
            prev = int'(tri_out);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        enable_240hz = 1'b0;
        enable_120hz = 1'b0;
        reg_4008     = 8'h00;
        reg_400A     = 8'h03;
        reg_400B     = 8'h00;
        reg_change   = 1'b0;
        channel_en   = 1'b1;
        saw_mode     = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_tri_out", int'(tri_out), 0);
        check("rst_length_active", int'(length_active), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("post_rst_tri_out", int'(tri_out), 15);

        // Halted, period 3, length index 1
        reg_4008 = 8'hFF;
        reg_400B = 8'h08;
        toggle();
        tick(3);
        check("t2_model_len", m.len, 254);
        check("t2_length_active", int'(length_active), 1);
        strobe(1'b0);
        record(100);
        check("t2_enough_steps", int'(chg_v.size() >= 16), 1);
        if (chg_v.size() >= 16) begin
            check("t2_first_step", chg_v[0], 14);
            check("t2_bottom", chg_v[14], 0);
            check("t2_after_double_zero", chg_v[15], 1);
            check("t2_step_spacing", chg_t[1] - chg_t[0], 4);
        end

        // Period 1, sawtooth
        reg_400A = 8'h01;
        saw_mode = 1'b1;
        tick(10);
        record(40);
`ifdef TRI_ULTRASONIC_MUTE_EN
        check("t6_mute_steps", chg_v.size(), 0);
        check("t6_mute_code", int'(tri_out), 7);
`else
        check("t6_enough_steps", int'(chg_v.size() >= 2), 1);
        if (chg_v.size() >= 2) begin
            check("t6_saw_spacing", chg_t[1] - chg_t[0], 4);
            check("t6_saw_down_by_one", (chg_v[0] - chg_v[1]) & 15, 1);
        end
`endif

        // Reset mid-run at seq 9
        reg_400A = 8'h03;
        saw_mode = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if (m.seq == 9) found = 1'b1;
        end
        check("t1_reached_seq9", int'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_tri_out_async", int'(tri_out), 0);
        check("t1_length_active_async", int'(length_active), 0);
        @(negedge clk);
        reg_change    = 1'b0;
        m_reload_edge = -1;
        tick(1);
        check("t1_model_seq", m.seq, 0);
        rst_n = 1'b1;
        tick(2);
        check("t1_tri_out_after", int'(tri_out), 15);

        // Channel enable
        reg_4008 = 8'hFF;
        reg_400B = 8'h08;
        toggle();
        tick(3);
        check("t4_loaded", int'(length_active), 1);
        channel_en = 1'b0;
        tick(1);
        check("t4_disable_clears", int'(length_active), 0);
        toggle();
        tick(5);
        check("t4_reload_while_off", int'(length_active), 0);
        channel_en = 1'b1;
        tick(5);
        check("t4_enable_no_reload", int'(length_active), 0);

        // Linear counter runs out, length decrements
        reg_4008 = 8'h04;
        reg_400B = 8'h00;
        toggle();
        tick(3);
        strobe(1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(8);
            strobe(1'b0);
        end
        check("t3_model_lin", m.lin, 0);
        tick(3);
        record(40);
        check("t3_frozen", chg_v.size(), 0);
        for (int i = 0; i < 9; i++) begin
            strobe(1'b1);
            tick(2);
        end
        check("t3_len_one_left", int'(length_active), 1);
        strobe(1'b1);
        tick(2);
        check("t3_len_zero", int'(length_active), 0);

        // Reload coincident with both frame strobes
        reg_4008 = 8'h04;
        reg_400B = 8'h18;
        toggle();
        tick(2);
        enable_240hz = 1'b1;
        enable_120hz = 1'b1;
        tick(1);
        enable_240hz = 1'b0;
        enable_120hz = 1'b0;
        check("t5_model_len", m.len, 2);
        check("t5_model_lin", m.lin, 4);
        check("t5_active", int'(length_active), 1);
        strobe(1'b1);
        tick(1);
        check("t5_after_one_dec", int'(length_active), 1);
        strobe(1'b1);
        tick(1);
        check("t5_after_two_dec", int'(length_active), 0);

        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
